// File: rtl/crossbar_pkg.sv
// crossbar_pkg -- shared types and constants for the crossbar controller.
//
// Contents:
//   state_t        : controller FSM states (IDLE, LOAD, P1, P2, P3)
//   SEL_*          : datapath mux select codes driven on S
//   NUM_REGS       : number of crossbar registers (R1..R4)
//   reps_to_count  : maps the 2-bit repetition request onto a 3-bit count
//                    (0 encodes four repetitions)
package crossbar_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      P1   = 3'd2,
      P2   = 3'd3,
      P3   = 3'd4
   } state_t;

   localparam logic [1:0] SEL_EXT = 2'b00;
   localparam logic [1:0] SEL_P1  = 2'b01;
   localparam logic [1:0] SEL_P2  = 2'b10;
   localparam logic [1:0] SEL_P3  = 2'b11;

   localparam int unsigned NUM_REGS = 4;

   function automatic logic [2:0] reps_to_count(input logic [1:0] reps);
      return (reps == 2'd0) ? 3'd4 : {1'b0, reps};
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-requester arbiter with a tie-break pointer.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests (bit 0 = load, bit 1 = permute)
//   accept     : the requester side is able to take a grant this cycle
//   gnt[1:0]   : one-hot grant, combinational from req and the pointer
//
// Configuration macro: CROSSBAR_CTRL_RR_EN
//   defined   : round-robin, the last winner loses the next tie
//   undefined : fixed priority, req[0] always wins a tie
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] gnt
);

   // ptr_q = 0: req[0] wins a tie; ptr_q = 1: req[1] wins a tie.
   logic ptr_q;
   logic ptr_nxt;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || !ptr_q)) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

`ifdef CROSSBAR_CTRL_RR_EN
   // The winner drops to low priority for the next tie.
   assign ptr_nxt = gnt[0];
`else
   assign ptr_nxt = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (accept && (|req)) begin
         ptr_q <= ptr_nxt;
      end
   end

endmodule

// File: rtl/crossbar_ctrl.sv
// crossbar_ctrl -- sequencer for a four-register crossbar datapath.
//
// Performs either an external load (one LOAD cycle writing the masked
// registers from external data) or a permutation (P1 -> P2 -> P3 repeated
// 1..4 times). Requests are arbitrated only while IDLE.
//
// Ports:
//   Clock, Resetn : clock, asynchronous active-low reset
//   ld_req        : load request          ld_mask   : target registers (bit0 = R1)
//   ld_gnt        : load accepted pulse   perm_req  : permute request
//   perm_reps     : repetitions (0 = 4)   perm_gnt  : permute accepted pulse
//   S             : datapath mux select   Extern    : external tristate enable
//   RinExt        : per-register external load enables
//   busy          : controller not IDLE   done      : operation complete pulse
//   dbg_state     : current FSM state
//
// Handshake: ld_req/perm_req are level requests held by the requester until
// its grant appears. A grant is high exactly in the first cycle of the
// operation and marks the edge where ld_mask/perm_reps were captured; the
// controller ignores requests and input changes until it is IDLE again.
//
// Configuration macro: CROSSBAR_CTRL_RR_EN selects round-robin tie-break
// (undefined: load always wins a tie).
module crossbar_ctrl
   import crossbar_pkg::*;
(
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                ld_req,
   input  logic [NUM_REGS-1:0] ld_mask,
   output logic                ld_gnt,
   input  logic                perm_req,
   input  logic [1:0]          perm_reps,
   output logic                perm_gnt,
   output logic [1:0]          S,
   output logic                Extern,
   output logic [NUM_REGS-1:0] RinExt,
   output logic                busy,
   output logic                done,
   output state_t              dbg_state
);

   state_t              state_q, state_nxt;
   logic [NUM_REGS-1:0] mask_q, mask_nxt;
   logic [2:0]          cnt_q, cnt_nxt;
   logic                ld_gnt_q, ld_gnt_nxt;
   logic                perm_gnt_q, perm_gnt_nxt;
   logic                done_q, done_nxt;
   logic                idle;
   logic [1:0]          arb_req;
   logic [1:0]          arb_gnt;

   assign idle    = (state_q == IDLE);
   assign arb_req = {perm_req, ld_req} & {2{idle}};

   rr_arb2 u_arb (
      .clk    (Clock),
      .rst_n  (Resetn),
      .req    (arb_req),
      .accept (idle),
      .gnt    (arb_gnt)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q    <= IDLE;
         mask_q     <= '0;
         cnt_q      <= 3'd0;
         ld_gnt_q   <= 1'b0;
         perm_gnt_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         mask_q     <= mask_nxt;
         cnt_q      <= cnt_nxt;
         ld_gnt_q   <= ld_gnt_nxt;
         perm_gnt_q <= perm_gnt_nxt;
         done_q     <= done_nxt;
      end
   end

   always_comb begin
      state_nxt    = state_q;
      mask_nxt     = mask_q;
      cnt_nxt      = cnt_q;
      ld_gnt_nxt   = 1'b0;
      perm_gnt_nxt = 1'b0;
      done_nxt     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_gnt[0]) begin
               state_nxt  = LOAD;
               mask_nxt   = ld_mask;
               ld_gnt_nxt = 1'b1;
            end else if (arb_gnt[1]) begin
               state_nxt    = P1;
               cnt_nxt      = reps_to_count(perm_reps);
               perm_gnt_nxt = 1'b1;
            end
         end
         LOAD: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         P1: state_nxt = P2;
         P2: state_nxt = P3;
         P3: begin
            // Counter holds the repetitions still to run including this one.
            cnt_nxt = cnt_q - 3'd1;
            if (cnt_q != 3'd1) begin
               state_nxt = P1;
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath controls are decoded from state alone.
   always_comb begin
      S      = SEL_EXT;
      Extern = 1'b0;
      RinExt = '0;
      case (state_q)
         LOAD: begin
            Extern = 1'b1;
            RinExt = mask_q;
         end
         P1:      S = SEL_P1;
         P2:      S = SEL_P2;
         P3:      S = SEL_P3;
         default: S = SEL_EXT;
      endcase
   end

   assign ld_gnt    = ld_gnt_q;
   assign perm_gnt  = perm_gnt_q;
   assign done      = done_q;
   assign busy      = !idle;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_crossbar_ctrl.sv
// tb_crossbar_ctrl -- directed scenarios plus randomized traffic for
// crossbar_ctrl, checked cycle by cycle against a schedule-queue model.
module tb_crossbar_ctrl;
   import crossbar_pkg::*;

   localparam int W = 11;  // {ld_gnt, perm_gnt, S[1:0], Extern, RinExt[3:0], busy, done}
`ifdef CROSSBAR_CTRL_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       Clock     = 1'b0;
   logic       Resetn    = 1'b1;
   logic       ld_req    = 1'b0;
   logic [3:0] ld_mask   = 4'h0;
   logic       perm_req  = 1'b0;
   logic [1:0] perm_reps = 2'd0;
   logic       ld_gnt, perm_gnt, Extern, busy, done;
   logic [1:0] S;
   logic [3:0] RinExt;
   state_t     dbg_state;

   crossbar_ctrl dut (
      .Clock     (Clock),
      .Resetn    (Resetn),
      .ld_req    (ld_req),
      .ld_mask   (ld_mask),
      .ld_gnt    (ld_gnt),
      .perm_req  (perm_req),
      .perm_reps (perm_reps),
      .perm_gnt  (perm_gnt),
      .S         (S),
      .Extern    (Extern),
      .RinExt    (RinExt),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state)
   );

   always #5 Clock = ~Clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Each accepted operation is expanded into its full list of per-cycle
   // output words; the controller is idle whenever that list is empty.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur = '0;
   bit           favor_perm = 1'b0;  // last winner loses the next tie (RR only)

   function automatic logic [W-1:0] mk(input logic gl, input logic gp, input logic [1:0] s,
                                       input logic ext, input logic [3:0] rin,
                                       input logic bsy, input logic dn);
      return {gl, gp, s, ext, rin, bsy, dn};
   endfunction

   task automatic model_edge();
      int  n;
      bit  take_ld;
      if (exp_q.size() == 0) begin
         take_ld = ld_req && !(perm_req && favor_perm);
         if (take_ld) begin
            exp_q.push_back(mk(1'b1, 1'b0, 2'd0, 1'b1, ld_mask, 1'b1, 1'b0));
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1));
            if (RR) favor_perm = 1'b1;
         end else if (perm_req) begin
            n = (perm_reps == 2'd0) ? 4 : int'(perm_reps);
            for (int r = 0; r < n; r++)
               for (int p = 1; p <= 3; p++)
                  exp_q.push_back(mk(1'b0, (r == 0 && p == 1), 2'(p), 1'b0, 4'h0, 1'b1, 1'b0));
            exp_q.push_back(mk(1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0, 1'b1));
            favor_perm = 1'b0;
         end
      end
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      else cur = '0;
   endtask

   task automatic compare_all(input string where);
      check({where, ".ld_gnt"},   ld_gnt,   cur[10]);
      check({where, ".perm_gnt"}, perm_gnt, cur[9]);
      check({where, ".S"},        S,        cur[8:7]);
      check({where, ".Extern"},   Extern,   cur[6]);
      check({where, ".RinExt"},   RinExt,   cur[5:2]);
      check({where, ".busy"},     busy,     cur[1]);
      check({where, ".done"},     done,     cur[0]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge Clock);
      if (Resetn) model_edge();
      #1;
      compare_all("cyc");
   endtask

   task automatic do_reset();
      Resetn = 1'b0;
      exp_q.delete();
      cur        = '0;
      favor_perm = 1'b0;
      #1;
      compare_all("rst");
      check("rst.state", dbg_state, IDLE);
   endtask

   // ---------------- stimulus ----------------
   int n;
   int g[2];
   int ngr;
   bit prev_done;

   initial begin
      #2;
      do_reset();
      step();
      step();
      Resetn = 1'b1;

      // load with mask 0101; mask changes after acceptance must not matter
      ld_req = 1'b1; ld_mask = 4'b0101;
      step();
      check("load.rinext", RinExt, 4'b0101);
      ld_req = 1'b0; ld_mask = 4'b1010;
      step();
      check("load.done", done, 1'b1);
      step();

      // permutation with two repetitions
      perm_req = 1'b1; perm_reps = 2'd2;
      step();
      perm_req = 1'b0; perm_reps = 2'd3;
      repeat (8) step();

      // perm_reps = 0 runs four repetitions: 12 busy cycles
      perm_req = 1'b1; perm_reps = 2'd0;
      step();
      perm_req = 1'b0;
      n = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         if (busy) n++;
         step();
      end
      check("perm0.len", n, 12);
      check("perm0.done_seen", done, 1'b1);
      step();

      // load zero mask is a legal one-cycle load
      ld_req = 1'b1; ld_mask = 4'h0;
      step();
      ld_req = 1'b0;
      step();
      step();

      // both requests held for two operations
      ld_req = 1'b1; perm_req = 1'b1; ld_mask = 4'hF; perm_reps = 2'd1;
      ngr = 0;
      for (int i = 0; i < 30 && ngr < 2; i++) begin
         step();
         if (ld_gnt)   begin g[ngr] = 1; ngr++; end
         else if (perm_gnt) begin g[ngr] = 2; ngr++; end
      end
      check("both.count", ngr, 2);
      check("both.first", g[0], 1);
      check("both.second", g[1], RR ? 2 : 1);
      ld_req = 1'b0; perm_req = 1'b0;
      repeat (6) step();

      // reset dropped during P2
      perm_req = 1'b1; perm_reps = 2'd3;
      step();
      perm_req = 1'b0;
      step();
      check("p2rst.in_p2", S, SEL_P2);
      do_reset();
      step();
      Resetn = 1'b1;
      step();
      step();
      ld_req = 1'b1; ld_mask = 4'b0011;
      step();
      check("p2rst.regrant", ld_gnt, 1'b1);
      ld_req = 1'b0;
      step();
      step();

      // load request raised during P2 and held: accepted at the done edge
      perm_req = 1'b1; perm_reps = 2'd1;
      step();
      perm_req = 1'b0;
      step();
      ld_req = 1'b1; ld_mask = 4'h9;
      prev_done = 1'b0;
      for (int i = 0; i < 10 && !ld_gnt; i++) begin
         prev_done = done;
         step();
      end
      check("hold.gnt", ld_gnt, 1'b1);
      check("hold.no_gap", prev_done, 1'b1);
      ld_req = 1'b0;
      step();
      step();

      // randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         ld_req    = ($urandom_range(0, 3) == 0);
         ld_mask   = 4'($urandom_range(0, 15));
         perm_req  = ($urandom_range(0, 3) == 0);
         perm_reps = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            step();
            Resetn = 1'b1;
         end else begin
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
